// File: rtl/atbs_threshold_scheduler.sv
// Threshold DAC / comparator sequencer for fixed-window threshold-based sampling.
// Owns the window centre, drives both threshold DACs and turns crossings into signed events.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start_i with enable_i high
// LOAD    | new DAC codes present, phi_dac_o strobe
// SETTLE  | DAC settling down-counter running
// COMPARE | phi_comp_o strobe
// DECIDE  | comparator outputs sampled, centre moves on a crossing
module atbs_threshold_scheduler #(
    parameter int DAC_BITWIDTH      = 8,
    parameter int DAC_SETTLING_CLKS = 10
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    input  logic                    enable_i,
    input  logic                    start_i,
    input  logic                    comp_upper_i,
    input  logic                    comp_lower_i,
    input  logic [DAC_BITWIDTH-1:0] window_i,
    input  logic [DAC_BITWIDTH-1:0] step_i,
    output logic [DAC_BITWIDTH-1:0] dac_upper_o,
    output logic [DAC_BITWIDTH-1:0] dac_lower_o,
    output logic                    phi_dac_o,
    output logic                    phi_comp_o,
    output logic                    event_valid_o,
    output logic                    event_up_o,
    output logic                    overflow_o,
    output logic                    underflow_o,
    output logic                    idle_o
);
    localparam int N     = DAC_BITWIDTH;
    localparam int CNT_W = (DAC_SETTLING_CLKS > 1) ? $clog2(DAC_SETTLING_CLKS) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DAC_SETTLING_CLKS - 1);
    localparam logic [N-1:0]     CODE_MAX    = {N{1'b1}};
    localparam logic [N-1:0]     CODE_MID    = {1'b1, {(N-1){1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DECIDE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [N-1:0]     centre_q, centre_d;
    logic [N-1:0]     dac_upper_q, dac_upper_d;
    logic [N-1:0]     dac_lower_q, dac_lower_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ev_valid_q, ev_valid_d;
    logic             ev_up_q, ev_up_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             load_codes;

    logic [N-1:0] step_eff;
    logic [N:0]   centre_inc, centre_dec, thr_hi, thr_lo;

    assign step_eff   = (step_i == '0) ? N'(1) : step_i;
    assign centre_inc = {1'b0, centre_q} + {1'b0, step_eff};
    assign centre_dec = {1'b0, centre_q} - {1'b0, step_eff};

    always_comb begin
        state_d    = state_q;
        centre_d   = centre_q;
        cnt_d      = cnt_q;
        ev_valid_d = 1'b0;
        ev_up_d    = ev_up_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        load_codes = 1'b0;
        if (!enable_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d    = S_LOAD;
                        centre_d   = CODE_MID;
                        ovf_d      = 1'b0;
                        unf_d      = 1'b0;
                        load_codes = 1'b1;
                    end
                end
                S_LOAD: begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LAST;
                end
                S_SETTLE: begin
                    if (cnt_q == '0) state_d = S_COMPARE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                S_COMPARE: state_d = S_DECIDE;
                S_DECIDE: begin
                    // both high: input above window; both low: below; otherwise keep polling
                    if (comp_upper_i && comp_lower_i) begin
                        state_d    = S_LOAD;
                        ev_valid_d = 1'b1;
                        ev_up_d    = 1'b1;
                        load_codes = 1'b1;
                        if (centre_q == CODE_MAX) ovf_d = 1'b1;
                        centre_d = centre_inc[N] ? CODE_MAX : centre_inc[N-1:0];
                    end else if (!comp_upper_i && !comp_lower_i) begin
                        state_d    = S_LOAD;
                        ev_valid_d = 1'b1;
                        ev_up_d    = 1'b0;
                        load_codes = 1'b1;
                        if (centre_q == '0) unf_d = 1'b1;
                        centre_d = centre_dec[N] ? '0 : centre_dec[N-1:0];
                    end else begin
                        state_d = S_COMPARE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign thr_hi = {1'b0, centre_d} + {1'b0, window_i};
    assign thr_lo = {1'b0, centre_d} - {1'b0, window_i};

    always_comb begin
        dac_upper_d = dac_upper_q;
        dac_lower_d = dac_lower_q;
        if (load_codes) begin
            dac_upper_d = thr_hi[N] ? CODE_MAX : thr_hi[N-1:0];
            dac_lower_d = thr_lo[N] ? '0 : thr_lo[N-1:0];
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            centre_q    <= CODE_MID;
            dac_upper_q <= CODE_MAX;
            dac_lower_q <= '0;
            cnt_q       <= '0;
            ev_valid_q  <= 1'b0;
            ev_up_q     <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            centre_q    <= centre_d;
            dac_upper_q <= dac_upper_d;
            dac_lower_q <= dac_lower_d;
            cnt_q       <= cnt_d;
            ev_valid_q  <= ev_valid_d;
            ev_up_q     <= ev_up_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign dac_upper_o   = dac_upper_q;
    assign dac_lower_o   = dac_lower_q;
    assign phi_dac_o     = (state_q == S_LOAD);
    assign phi_comp_o    = (state_q == S_COMPARE);
    assign event_valid_o = ev_valid_q;
    assign event_up_o    = ev_up_q;
    assign overflow_o    = ovf_q;
    assign underflow_o   = unf_q;
    assign idle_o        = (state_q == S_IDLE);

endmodule

// File: tb/tb_atbs_threshold_scheduler.sv
// Self-checking bench for atbs_threshold_scheduler (N=8, S=10): ramp vector table with an
// event scoreboard, plus hand-written window, abort, inconsistent and async-reset sequences.
module tb_atbs_threshold_scheduler;
    logic       clk, rst_n, enable, start, cu, cl;
    logic [7:0] window, step;
    logic [7:0] dac_upper, dac_lower;
    logic       phi_dac, phi_comp, ev_valid, ev_up, ovf, unf, idle;

    atbs_threshold_scheduler #(.DAC_BITWIDTH(8), .DAC_SETTLING_CLKS(10)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .start_i(start),
        .comp_upper_i(cu), .comp_lower_i(cl), .window_i(window), .step_i(step),
        .dac_upper_o(dac_upper), .dac_lower_o(dac_lower), .phi_dac_o(phi_dac),
        .phi_comp_o(phi_comp), .event_valid_o(ev_valid), .event_up_o(ev_up),
        .overflow_o(ovf), .underflow_o(unf), .idle_o(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int up; int upper; int lower; int ovf; int unf;
    } exp_ev_t;

    typedef struct {
        int window; int step; int cu; int cl; int n_ev;
        int exp_upper; int exp_lower; int exp_ovf; int exp_unf;
    } vec_t;

    exp_ev_t exp_q[$];
    vec_t    vecs[5];
    int      checks = 0;
    int      failures = 0;
    int      ev_seen = 0;
    int      since = 0;
    int      armed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // scoreboard side: every event popped against the model, plus event spacing
    always @(negedge clk) begin
        if (rst_n) begin
            since++;
            if (idle) armed = 0;
            if (ev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    exp_ev_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("ev%0d_up", ev_seen), int'(ev_up), e.up);
                    chk($sformatf("ev%0d_upper", ev_seen), int'(dac_upper), e.upper);
                    chk($sformatf("ev%0d_lower", ev_seen), int'(dac_lower), e.lower);
                    chk($sformatf("ev%0d_ovf", ev_seen), int'(ovf), e.ovf);
                    chk($sformatf("ev%0d_unf", ev_seen), int'(unf), e.unf);
                end
                chk("ev_with_load", int'(phi_dac), 1);
                if (armed != 0) chk($sformatf("ev%0d_gap", ev_seen), since, 13);
                ev_seen++;
            end
            if (phi_dac) begin
                armed = 1;
                since = 0;
            end
        end
    end

    function automatic void push_model(input vec_t v);
        int c, s, o, u;
        c = 128; o = 0; u = 0;
        s = (v.step == 0) ? 1 : v.step;
        for (int k = 0; k < v.n_ev; k++) begin
            exp_ev_t e;
            if (v.cu == 1 && v.cl == 1) begin
                if (c == 255) o = 1;
                c = (c + s > 255) ? 255 : c + s;
                e.up = 1;
            end else begin
                if (c == 0) u = 1;
                c = (c - s < 0) ? 0 : c - s;
                e.up = 0;
            end
            e.upper = (c + v.window > 255) ? 255 : c + v.window;
            e.lower = (c - v.window < 0) ? 0 : c - v.window;
            e.ovf = o; e.unf = u;
            exp_q.push_back(e);
        end
    endfunction

    // returns at the sampling point of cycle 1 (the LOAD cycle)
    task automatic do_start(input int w, input int s, input int up_in, input int lo_in);
        @(negedge clk);
        window = 8'(w); step = 8'(s); cu = up_in[0]; cl = lo_in[0];
        enable = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop(input string name);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk({name, "_idle"}, int'(idle), 1);
    endtask

    task automatic comp_pattern(input string name, input int last);
        int bad_comp, bad_dac;
        bad_comp = 0; bad_dac = 0;
        for (int n = 2; n <= last; n++) begin
            @(negedge clk);
            if (int'(phi_comp) != int'(n >= 12 && n % 2 == 0)) bad_comp++;
            if (phi_dac) bad_dac++;
        end
        chk({name, "_comp_cadence_errs"}, bad_comp, 0);
        chk({name, "_reload_count"}, bad_dac, 0);
    endtask

    initial begin
        vecs[0] = '{window: 3,   step: 0,  cu: 0, cl: 0, n_ev: 5,  exp_upper: 126, exp_lower: 120, exp_ovf: 0, exp_unf: 0};
        vecs[1] = '{window: 200, step: 50, cu: 1, cl: 1, n_ev: 4,  exp_upper: 255, exp_lower: 55,  exp_ovf: 1, exp_unf: 0};
        vecs[2] = '{window: 0,   step: 7,  cu: 0, cl: 0, n_ev: 3,  exp_upper: 107, exp_lower: 107, exp_ovf: 0, exp_unf: 0};
        vecs[3] = '{window: 16,  step: 4,  cu: 0, cl: 0, n_ev: 33, exp_upper: 16,  exp_lower: 0,   exp_ovf: 0, exp_unf: 1};
        vecs[4] = '{window: 16,  step: 4,  cu: 1, cl: 1, n_ev: 33, exp_upper: 255, exp_lower: 239, exp_ovf: 1, exp_unf: 0};

        rst_n = 1'b0; enable = 1'b0; start = 1'b0; cu = 1'b0; cl = 1'b1;
        window = 8'd16; step = 8'd4;
        repeat (3) @(negedge clk);
        chk("rst_upper", int'(dac_upper), 255);
        chk("rst_lower", int'(dac_lower), 0);
        chk("rst_idle", int'(idle), 1);
        chk("rst_strobes", int'({phi_dac, phi_comp, ev_valid}), 0);
        chk("rst_flags", int'({ev_up, ovf, unf}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // in window: one load, then comparator strobes every 2 cycles from cycle 12
        do_start(16, 4, 0, 1);
        chk("win_phi_dac", int'(phi_dac), 1);
        chk("win_upper", int'(dac_upper), 144);
        chk("win_lower", int'(dac_lower), 112);
        chk("win_idle_low", int'(idle), 0);
        comp_pattern("win", 30);
        do_stop("win");

        foreach (vecs[t]) begin
            push_model(vecs[t]);
            ev_seen = 0;
            do_start(vecs[t].window, vecs[t].step, vecs[t].cu, vecs[t].cl);
            for (int i = 0; i < vecs[t].n_ev * 13 + 30 && ev_seen < vecs[t].n_ev; i++)
                @(negedge clk);
            chk($sformatf("vec%0d_events", t), ev_seen, vecs[t].n_ev);
            chk($sformatf("vec%0d_upper", t), int'(dac_upper), vecs[t].exp_upper);
            chk($sformatf("vec%0d_lower", t), int'(dac_lower), vecs[t].exp_lower);
            chk($sformatf("vec%0d_ovf", t), int'(ovf), vecs[t].exp_ovf);
            chk($sformatf("vec%0d_unf", t), int'(unf), vecs[t].exp_unf);
            chk($sformatf("vec%0d_pending", t), exp_q.size(), 0);
            exp_q.delete();
            do_stop($sformatf("vec%0d", t));
            chk($sformatf("vec%0d_hold_ovf", t), int'(ovf), vecs[t].exp_ovf);
            chk($sformatf("vec%0d_hold_upper", t), int'(dac_upper), vecs[t].exp_upper);
        end

        // enable drop in 5th SETTLE cycle, straight after the overflowing up ramp
        do_start(16, 4, 0, 1);
        chk("drop_ovf_cleared", int'(ovf), 0);
        chk("drop_upper", int'(dac_upper), 144);
        chk("drop_lower", int'(dac_lower), 112);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_idle_next", int'(idle), 1);
        begin
            int strobes;
            strobes = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (phi_comp || phi_dac || ev_valid) strobes++;
            end
            chk("drop_no_strobes", strobes, 0);
        end
        chk("drop_hold_upper", int'(dac_upper), 144);
        do_start(16, 4, 0, 1);
        chk("restart_upper", int'(dac_upper), 144);
        chk("restart_lower", int'(dac_lower), 112);
        chk("restart_flags", int'({ovf, unf}), 0);
        do_stop("restart");

        // inconsistent comparators: keep polling, no events, codes untouched
        do_start(16, 4, 1, 0);
        comp_pattern("inc", 40);
        chk("inc_upper", int'(dac_upper), 144);
        chk("inc_lower", int'(dac_lower), 112);
        do_stop("inc");

        // asynchronous reset while phi_comp_o is high
        do_start(10, 4, 0, 1);
        chk("ar_upper_pre", int'(dac_upper), 138);
        repeat (11) @(negedge clk);
        chk("ar_phi_comp_pre", int'(phi_comp), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_phi_comp", int'(phi_comp), 0);
        chk("ar_upper", int'(dac_upper), 255);
        chk("ar_lower", int'(dac_lower), 0);
        chk("ar_idle", int'(idle), 1);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_stays_idle", int'(idle), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
